// File: rtl/fifo_wptr_full.sv
// Purpose : write-side pointer/flag control for an async FIFO (write address, Gray write pointer,
//           full, almost-full, occupancy estimate, sticky overflow).
// Latency : an accepted write updates the flags on its own edge; read-pointer changes reach the
//           flags on the 3rd wclk edge (2-flop sync + flag register).
// Backpr. : wfull_o blocks writes; a write attempted while full is dropped and sets wovf_o.
//
// Ports:
//   wclk_i          write-domain clock (posedge)
//   wrst_n_i        synchronous active-low reset
//   winc_i          write request
//   rptr_gray_i     Gray read pointer from the read clock domain (asynchronous)
//   wovf_clr_i      one-cycle clear for the sticky overflow flag
//   waddr_o         memory write address (low bits of the binary write pointer)
//   wptr_o          registered Gray write pointer for the read-side synchronizer
//   wfull_o         FIFO full
//   walmost_full_o  occupancy >= DEPTH - AF_MARGIN
//   wcount_o        occupancy estimate 0..DEPTH as seen from wclk
//   wovf_o          sticky: a write was attempted while full
module fifo_wptr_full #(
  parameter int ADDR_SIZE = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                 wclk_i,
  input  logic                 wrst_n_i,
  input  logic                 winc_i,
  input  logic [ADDR_SIZE:0]   rptr_gray_i,
  input  logic                 wovf_clr_i,
  output logic [ADDR_SIZE-1:0] waddr_o,
  output logic [ADDR_SIZE:0]   wptr_o,
  output logic                 wfull_o,
  output logic                 walmost_full_o,
  output logic [ADDR_SIZE:0]   wcount_o,
  output logic                 wovf_o
);

  localparam int A     = ADDR_SIZE;
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [A:0] AF_LEVEL = (A+1)'(DEPTH - AF_MARGIN);

  // Registered state
  logic [A:0] wbin_q, wbin_d;
  logic [A:0] wptr_q, wptr_d;
  logic [A:0] wq1_q, wq2_q;
  logic       wfull_q, wfull_d;
  logic       waf_q, waf_d;
  logic [A:0] wcount_q, wcount_d;
  logic       wovf_q, wovf_d;

  // Combinational helpers
  logic       wacc;
  logic [A:0] rbin_s;
  logic [A:0] occ;
  logic [A:0] full_cmp;

  function automatic logic [A:0] gray2bin(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    wacc     = winc_i & ~wfull_q;
    wbin_d   = wbin_q + {{A{1'b0}}, wacc};
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    rbin_s   = gray2bin(wq2_q);
    occ      = wbin_d - rbin_s;
    // Full when the write pointer is exactly one lap ahead of the synced read pointer;
    // in Gray code that is the read pointer with its two MSBs inverted.
    full_cmp = {~wq2_q[A:A-1], wq2_q[A-2:0]};
    wfull_d  = (wptr_d == full_cmp);
    waf_d    = (occ >= AF_LEVEL);
    wcount_d = occ;
    // Set has priority over clear so a coincident overflow is never lost.
    wovf_d   = (winc_i & wfull_q) | (wovf_q & ~wovf_clr_i);
  end

  always_ff @(posedge wclk_i) begin
    if (!wrst_n_i) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wq1_q    <= '0;
      wq2_q    <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wcount_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wq1_q    <= rptr_gray_i;
      wq2_q    <= wq1_q;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wcount_q <= wcount_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr_o        = wbin_q[A-1:0];
  assign wptr_o         = wptr_q;
  assign wfull_o        = wfull_q;
  assign walmost_full_o = waf_q;
  assign wcount_o       = wcount_q;
  assign wovf_o         = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed stimulus, a count-based occupancy model compared every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_fifo_wptr_full;

  localparam int A     = 4;
  localparam int DEPTH = 16;
  localparam int MOD   = 32;

  logic         clk = 1'b0;
  logic         wrst_n;
  logic         winc;
  logic [A:0]   rptr_gray;
  logic         wovf_clr;
  logic [A-1:0] waddr;
  logic [A:0]   wptr;
  logic         wfull;
  logic         walmost_full;
  logic [A:0]   wcount;
  logic         wovf;

  int tests = 0;
  int fails = 0;

  fifo_wptr_full #(.ADDR_SIZE(A), .AF_MARGIN(2)) dut (
    .wclk_i        (clk),
    .wrst_n_i      (wrst_n),
    .winc_i        (winc),
    .rptr_gray_i   (rptr_gray),
    .wovf_clr_i    (wovf_clr),
    .waddr_o       (waddr),
    .wptr_o        (wptr),
    .wfull_o       (wfull),
    .walmost_full_o(walmost_full),
    .wcount_o      (wcount),
    .wovf_o        (wovf)
  );

  always #5 clk = ~clk;

  // ---------------- model: total writes mod 32 vs. read count seen two edges late -------------
  int m_wr   = 0;   // accepted writes, mod 32
  int m_r1   = 0;   // read count after first sync stage
  int m_r2   = 0;   // read count visible to the write side
  int m_occ  = 0;
  bit m_full = 0;
  bit m_af   = 0;
  bit m_ovf  = 0;
  bit chk_en = 0;

  function automatic int g2b(input logic [A:0] g);
    int v = 0;
    int bit_v = 0;
    for (int i = A; i >= 0; i--) begin
      bit_v = bit_v ^ int'(g[i]);
      v = v * 2 + bit_v;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (!wrst_n) begin
      m_wr = 0; m_r1 = 0; m_r2 = 0; m_occ = 0;
      m_full = 0; m_af = 0; m_ovf = 0;
      chk_en = 1;
    end else begin
      m_ovf  = (winc && m_full) || (m_ovf && !wovf_clr);
      if (winc && !m_full) m_wr = (m_wr + 1) % MOD;
      m_occ  = (m_wr - m_r2 + MOD) % MOD;
      m_full = (m_occ == DEPTH);
      m_af   = (m_occ >= DEPTH - 2);
      m_r2   = m_r1;
      m_r1   = g2b(rptr_gray);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_waddr",  int'(waddr),        m_wr % DEPTH);
      chk("mdl_wptr",   int'(wptr),         (m_wr >> 1) ^ m_wr);
      chk("mdl_wfull",  int'(wfull),        int'(m_full));
      chk("mdl_waf",    int'(walmost_full), int'(m_af));
      chk("mdl_wcount", int'(wcount),       m_occ);
      chk("mdl_wovf",   int'(wovf),         int'(m_ovf));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_waddr"},  int'(waddr), 0);
    chk({tag, "_wptr"},   int'(wptr), 0);
    chk({tag, "_wfull"},  int'(wfull), 0);
    chk({tag, "_waf"},    int'(walmost_full), 0);
    chk({tag, "_wcount"}, int'(wcount), 0);
    chk({tag, "_wovf"},   int'(wovf), 0);
  endtask

  initial begin
    wrst_n = 1'b0; winc = 1'b1; rptr_gray = 5'b00011; wovf_clr = 1'b0;

    // 1: reset for two edges with a write request and non-zero read pointer
    step(); step();
    chk_all_zero("rst");

    // 2: fill to full
    wrst_n = 1'b1; rptr_gray = 5'b00000; winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 13) chk("fill13_waf", int'(walmost_full), 0);
      if (i == 14) begin
        chk("fill14_waf", int'(walmost_full), 1);
        chk("fill14_wcount", int'(wcount), 14);
      end
      if (i == 15) chk("fill15_wfull", int'(wfull), 0);
    end
    chk("full_wfull",  int'(wfull), 1);
    chk("full_wcount", int'(wcount), 16);
    chk("full_waddr",  int'(waddr), 0);
    chk("full_wptr",   int'(wptr), 24);

    // 3: writes while full are rejected and set the sticky overflow
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovf_waddr", int'(waddr), 0);
      chk("ovf_wptr",  int'(wptr), 24);
      chk("ovf_set",   int'(wovf), 1);
    end
    winc = 1'b0;
    step();
    chk("ovf_hold", int'(wovf), 1);
    winc = 1'b1; wovf_clr = 1'b1;   // set and clear together: set wins
    step();
    chk("ovf_setwins", int'(wovf), 1);
    winc = 1'b0;
    step();
    chk("ovf_clr", int'(wovf), 0);
    wovf_clr = 1'b0;

    // 4: one read seen from the read domain, three-edge latency
    rptr_gray = 5'b00001;
    step();
    chk("rd_e1_wfull", int'(wfull), 1);
    chk("rd_e1_wcount", int'(wcount), 16);
    step();
    chk("rd_e2_wfull", int'(wfull), 1);
    step();
    chk("rd_e3_wfull",  int'(wfull), 0);
    chk("rd_e3_wcount", int'(wcount), 15);
    chk("rd_e3_waf",    int'(walmost_full), 1);

    // 5: read pointer catches up, then 16 writes wrap the pointer to 0
    rptr_gray = 5'b11000;
    step(); step(); step();
    chk("empty_wcount", int'(wcount), 0);
    chk("empty_wfull",  int'(wfull), 0);
    winc = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk("wrap_wptr",   int'(wptr), 0);
    chk("wrap_waddr",  int'(waddr), 0);
    chk("wrap_wfull",  int'(wfull), 1);
    chk("wrap_wcount", int'(wcount), 16);

    // 6: reset mid-operation after five writes
    winc = 1'b0; rptr_gray = 5'b00000; wrst_n = 1'b0;
    step();
    wrst_n = 1'b1; winc = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_waddr",  int'(waddr), 5);
    chk("pre_rst_wcount", int'(wcount), 5);
    wrst_n = 1'b0;
    step();
    chk_all_zero("midrst");
    wrst_n = 1'b1;
    step();
    chk("post_rst_waddr",  int'(waddr), 1);
    chk("post_rst_wcount", int'(wcount), 1);
    winc = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
